// File: rtl/xcvr_pkg.sv
// Shared transceiver definitions: receive FSM encoding, sample/word widths, sign-extension helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package xcvr_pkg;

    localparam int COMP_W   = 12;
    localparam int EXT_W    = 16;
    localparam int SAMPLE_W = 24;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rx_state_e;

    function automatic logic [EXT_W-1:0] sext(input logic [COMP_W-1:0] c);
        return {{(EXT_W-COMP_W){c[COMP_W-1]}}, c};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; DEPTH words total including the output register.
// Latency: write at edge N is visible on rd_vld_o after edge N+1.
// Backpressure: write refused when full unless a read happens in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             rd_vld_o,
    output logic [WIDTH-1:0] rd_dat_o,
    input  logic             rd_rdy_i
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic             rd_vld_q, rd_vld_d;
    logic [WIDTH-1:0] rd_dat_q, rd_dat_d;
    logic [AW:0]      mem_cnt, occ;
    logic             pop, wr_en, load;

    always_comb begin
        mem_cnt  = wptr_q - rptr_q;
        occ      = mem_cnt + {{AW{1'b0}}, rd_vld_q};
        pop      = rd_vld_q & rd_rdy_i;
        full_o   = (occ == FULL_CNT);
        empty_o  = (occ == '0);
        wr_en    = wr_vld_i & (~full_o | pop);
        // refill the output register whenever it is free or being emptied this cycle
        load     = (mem_cnt != '0) & (~rd_vld_q | pop);
        wptr_d   = wr_en ? wptr_q + ONE : wptr_q;
        rptr_d   = load ? rptr_q + ONE : rptr_q;
        rd_vld_d = load ? 1'b1 : (pop ? 1'b0 : rd_vld_q);
        rd_dat_d = load ? mem_q[rptr_q[AW-1:0]] : rd_dat_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            rd_vld_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rd_vld_q <= rd_vld_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_vld_o = rd_vld_q;
    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/rx_sample_packer.sv
// Packs 12-bit I/Q ADC samples into sign-extended 32-bit words through a FWFT FIFO, with drop stats.
// Latency: sample accepted at edge N appears on m_valid after edge N+1.
// Backpressure: m_ready stalls the output; samples arriving while full are dropped and counted.
module rx_sample_packer
    import xcvr_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter bit SWAP_IQ = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_enable,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    output logic [WORD_W-1:0]   m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                overflow,
    output logic [15:0]         drop_count,
    input  logic                clear_stats,
    output logic                busy
);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    rx_state_e         state_q, state_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [EXT_W-1:0]  i_ext, q_ext;
    logic [WORD_W-1:0] packed_word;
    logic              push_try, pop, drop;
    logic              fifo_full, fifo_empty;

    always_comb begin
        i_ext       = sext(adc_data[SAMPLE_W-1:COMP_W]);
        q_ext       = sext(adc_data[COMP_W-1:0]);
        packed_word = SWAP_IQ ? {q_ext, i_ext} : {i_ext, q_ext};
        push_try    = (state_q == ST_RUN) & rx_enable & adc_valid;
        pop         = m_valid & m_ready;
        drop        = push_try & fifo_full & ~pop;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (rx_enable) state_d = ST_RUN;
            ST_RUN:   if (!rx_enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (rx_enable) begin
                    state_d = ST_RUN;
                end else if (fifo_empty && !m_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // a clear in the same cycle as a drop wins, so both stats read zero afterwards
    always_comb begin
        overflow_d = overflow_q | drop;
        drop_cnt_d = (drop && drop_cnt_q != CNT_MAX) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        if (clear_stats) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_vld_i (push_try),
        .wr_dat_i (packed_word),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .rd_vld_o (m_valid),
        .rd_dat_o (m_data),
        .rd_rdy_i (m_ready)
    );

    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_sample_packer.sv
// Scoreboard bench for rx_sample_packer: a normal and an IQ-swapped instance share all inputs.
module tb_rx_sample_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_enable, adc_valid, m_ready, clear_stats;
    logic [23:0] adc_data;
    logic [31:0] m_data0, m_data1;
    logic        m_valid0, m_valid1, overflow0, overflow1, busy0, busy1;
    logic [15:0] drop_count0, drop_count1;

    int errors = 0;
    int checks = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        held_v[2];
    logic [31:0] held_d[2];

    always #5 clk = ~clk;

    rx_sample_packer #(.DEPTH(8), .SWAP_IQ(1'b0)) u_dut (
        .clk(clk), .reset(reset), .rx_enable(rx_enable), .adc_data(adc_data),
        .adc_valid(adc_valid), .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready),
        .overflow(overflow0), .drop_count(drop_count0), .clear_stats(clear_stats), .busy(busy0));

    rx_sample_packer #(.DEPTH(8), .SWAP_IQ(1'b1)) u_swap (
        .clk(clk), .reset(reset), .rx_enable(rx_enable), .adc_data(adc_data),
        .adc_valid(adc_valid), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready),
        .overflow(overflow1), .drop_count(drop_count1), .clear_stats(clear_stats), .busy(busy1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [23:0] s, input bit swap);
        logic [15:0] i16, q16;
        i16 = {{4{s[23]}}, s[23:12]};
        q16 = {{4{s[11]}}, s[11:0]};
        return swap ? {q16, i16} : {i16, q16};
    endfunction

    function automatic logic [23:0] smp(input int k);
        logic [31:0] v;
        v = (k * 32'h000A_3917) ^ 32'h008F_0F5A;
        return v[23:0];
    endfunction

    task automatic mon_step(input int id, input logic v, input logic [31:0] d);
        logic [31:0] e;
        if (held_v[id]) check($sformatf("hold_dut%0d", id), {v, d[30:0]}, {1'b1, held_d[id][30:0]});
        if (v && m_ready) begin
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word_dut%0d: got %h expected none", id, d);
            end else begin
                if (id == 0) e = q0.pop_front();
                else         e = q1.pop_front();
                check($sformatf("word_dut%0d", id), d, e);
            end
        end
        held_v[id] = v && !m_ready;
        held_d[id] = d;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            held_v[0] = 1'b0;
            held_v[1] = 1'b0;
        end else begin
            mon_step(0, m_valid0, m_data0);
            mon_step(1, m_valid1, m_data1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] s);
        adc_valid = 1'b1;
        adc_data  = s;
        cyc();
        adc_valid = 1'b0;
    endtask

    task automatic exp_s(input logic [23:0] s);
        q0.push_back(pack(s, 1'b0));
        q1.push_back(pack(s, 1'b1));
    endtask

    task automatic exp2(input logic [31:0] a, input logic [31:0] b);
        q0.push_back(a);
        q1.push_back(b);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            cyc();
            n++;
        end
        cyc();
        check(name, {31'd0, q0.size() == 0 && q1.size() == 0 && !m_valid0 && !m_valid1}, 32'd1);
    endtask

    task automatic stats(input string name, input logic ov, input logic [15:0] dc);
        check({name, "_ov"}, {30'd0, overflow0, overflow1}, {30'd0, ov, ov});
        check({name, "_dc"}, {drop_count0, drop_count1}, {dc, dc});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        held_v[0] = 1'b0; held_v[1] = 1'b0;
        reset = 1'b1; rx_enable = 1'b0; adc_valid = 1'b0; adc_data = '0;
        m_ready = 1'b0; clear_stats = 1'b0;
        cyc();
        check("rst_mvalid", {30'd0, m_valid0, m_valid1}, 32'd0);
        check("rst_mdata0", m_data0, 32'd0);
        check("rst_busy", {30'd0, busy0, busy1}, 32'd0);
        stats("rst", 1'b0, 16'd0);
        reset = 1'b0;

        // IDLE->RUN: sample in the enabling cycle is not captured
        rx_enable = 1'b1;
        send(24'h123456);
        check("run_busy", {30'd0, busy0, busy1}, 32'd3);
        m_ready = 1'b1;
        exp2(32'hFF00_07FF, 32'h07FF_FF00);
        send(24'hF007FF);
        check("lat_n", {30'd0, m_valid0, m_valid1}, 32'd0);
        cyc();
        check("lat_n1", {30'd0, m_valid0, m_valid1}, 32'd3);
        cyc();
        check("lat_n2", {30'd0, m_valid0, m_valid1}, 32'd0);

        // back-to-back packing vectors, full throughput
        exp2(32'h0000_0000, 32'h0000_0000);
        exp2(32'hF800_0001, 32'h0001_F800);
        exp2(32'h07FF_F800, 32'hF800_07FF);
        exp2(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exp2(32'h05A5_FA5A, 32'hFA5A_05A5);
        send(24'h000000); send(24'h800001); send(24'h7FF800);
        send(24'hFFFFFF); send(24'h5A5A5A);
        cyc();
        @(negedge clk); #1;
        check("throughput", {31'd0, q0.size() == 0 && q1.size() == 0}, 32'd1);
        cyc();

        // overflow: 11 samples into 8 entries with consumer stalled
        m_ready = 1'b0;
        for (int k = 0; k < 11; k++) begin
            if (k < 8) exp_s(smp(k));
            send(smp(k));
        end
        stats("ovf", 1'b1, 16'd3);
        cyc(); cyc();
        m_ready = 1'b1;
        wait_drain("ovf_drain");
        clear_stats = 1'b1;
        cyc();
        clear_stats = 1'b0;
        stats("clr", 1'b0, 16'd0);

        // full + simultaneous pop: no drop
        m_ready = 1'b0;
        for (int k = 20; k < 28; k++) begin
            exp_s(smp(k));
            send(smp(k));
        end
        m_ready = 1'b1;
        exp_s(smp(28));
        send(smp(28));
        m_ready = 1'b0;
        stats("pushpop", 1'b0, 16'd0);
        send(smp(29));
        stats("drop1", 1'b1, 16'd1);
        clear_stats = 1'b1;
        send(smp(30));
        clear_stats = 1'b0;
        stats("clr_drop", 1'b0, 16'd0);
        adc_valid = 1'b1;
        adc_data  = smp(31);
        repeat (70000) cyc();
        adc_valid = 1'b0;
        stats("sat", 1'b1, 16'hFFFF);
        clear_stats = 1'b1;
        m_ready = 1'b1;
        cyc();
        clear_stats = 1'b0;
        wait_drain("sat_drain");

        // drain: 5 held, enable drops, arrivals during DRAIN ignored
        m_ready = 1'b0;
        for (int k = 40; k < 45; k++) begin
            exp_s(smp(k));
            send(smp(k));
        end
        rx_enable = 1'b0;
        m_ready   = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 24'hABCDEF;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy0) n++;
            else break;
        end
        @(posedge clk); #1;
        adc_valid = 1'b0;
        check("drain_busy_cycles", n, 32'd6);
        check("drain_empty", {31'd0, q0.size() == 0 && q1.size() == 0}, 32'd1);

        // DRAIN->RUN keeps contents
        rx_enable = 1'b1;
        m_ready = 1'b0;
        cyc();
        for (int k = 50; k < 53; k++) begin
            exp_s(smp(k));
            send(smp(k));
        end
        rx_enable = 1'b0;
        cyc();
        check("redrain_busy", {30'd0, busy0, busy1}, 32'd3);
        rx_enable = 1'b1;
        cyc();
        exp_s(smp(53));
        send(smp(53));
        m_ready = 1'b1;
        wait_drain("rerun_drain");

        // reset mid-stream with 4 held
        m_ready = 1'b0;
        for (int k = 60; k < 64; k++) send(smp(k));
        #2;
        reset = 1'b1;
        #1;
        check("arst_mvalid", {30'd0, m_valid0, m_valid1}, 32'd0);
        check("arst_mdata", m_data0 | m_data1, 32'd0);
        check("arst_busy", {30'd0, busy0, busy1}, 32'd0);
        stats("arst", 1'b0, 16'd0);
        cyc();
        reset = 1'b0;
        m_ready = 1'b1;
        cyc();
        check("post_rst_busy", {30'd0, busy0, busy1}, 32'd3);
        repeat (4) cyc();
        exp_s(smp(70));
        send(smp(70));
        wait_drain("post_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
